apb_gpio: RTL and testbench

- Parametrised APB slave GPIO port that replaces the fixed 8-bit output-only and input-only peripherals with one bidirectional block.
- Each pin direction is configurable per bit. Adds atomic bit set/clear, input synchronisation, and optional edge-triggered interrupts.
- Sits on one PSEL line of the APB master. Pins connect to MCU top-level ports.

---
 rtl/gpio_pkg.sv | 29 ++
 rtl/gpio_sync.sv | 55 +++++
 rtl/apb_gpio.sv | 207 ++++++++++++++++++++
 tb/tb_apb_gpio.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gpio_pkg
// Purpose  : Shared constants and types for the APB GPIO block.
//            Register word indices (as decoded from PADDR[4:2]), the APB
//            handshake state type, and BSRR / width limits.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gpio_pkg;

  localparam int MAX_WIDTH      = 16;
  // BSRR upper half-word clears ODR bits
  localparam int BSRR_CLR_SHIFT = 16;

  // Word indices, i.e. byte offset >> 2
  localparam logic [2:0] MODER_OFS   = 3'd0;  // 0x00
  localparam logic [2:0] IDR_OFS     = 3'd1;  // 0x04
  localparam logic [2:0] ODR_OFS     = 3'd2;  // 0x08
  localparam logic [2:0] BSRR_OFS    = 3'd3;  // 0x0C
  localparam logic [2:0] RISE_EN_OFS = 3'd4;  // 0x10
  localparam logic [2:0] FALL_EN_OFS = 3'd5;  // 0x14
  localparam logic [2:0] ISR_OFS     = 3'd6;  // 0x18

  typedef enum logic {IDLE, ACK} apb_state_e;

endpackage
`default_nettype wire

// File: rtl/gpio_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gpio_sync
// Purpose  : Per-pin input synchroniser chain plus a one-cycle-delayed copy
//            of the synchronised value, giving raw edge strobes.
// Ports    : clk, rst        - clock, async active-high reset
//            pin_in          - asynchronous pin inputs
//            out_mode        - per-pin output mode (MODER); suppresses edges
//            sync            - last synchroniser stage
//            rise_raw        - sync 0->1 on an input-mode pin
//            fall_raw        - sync 1->0 on an input-mode pin
// Revision : 1.0 - initial release
// ============================================================================
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] out_mode,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise_raw,
  output logic [WIDTH-1:0] fall_raw
);

  logic [WIDTH-1:0] chain [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        chain[s] <= '0;
      end
      prev <= '0;
    end else begin
      chain[0] <= pin_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        chain[s] <= chain[s-1];
      end
      // prev follows sync unconditionally, so it is already current when a
      // pin flips from output to input and no stale edge can appear.
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign sync     = chain[SYNC_STAGES-1];
  assign rise_raw =  sync & ~prev & ~out_mode;
  assign fall_raw = ~sync &  prev & ~out_mode;

endmodule
`default_nettype wire

// File: rtl/apb_gpio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apb_gpio
// Purpose  : APB slave bidirectional GPIO port with per-bit direction,
//            atomic set/clear (BSRR), synchronised inputs and optional
//            edge-triggered interrupts. One wait state per transfer.
// Ports    : PCLK, PRESET    - clock, async active-high reset
//            PADDR..PSEL     - APB request (PADDR[4:2] decoded)
//            PRDATA, PREADY, PSLVERR - APB response, valid while PREADY=1
//            ioIn            - asynchronous pin inputs
//            ioOut, ioOe     - pin data (ODR) and output enable (MODER)
//            irq             - registered OR of ISR
// Config   : `define GPIO_IRQ_EN to build RISE_EN/FALL_EN/ISR and irq.
//            Without it offsets 0x10-0x18 return PSLVERR and irq is 0.
// Revision : 1.0 - initial release
// ============================================================================
module apb_gpio
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [31:0]      PADDR,
  input  logic [31:0]      PWDATA,
  input  logic             PWRITE,
  input  logic             PENABLE,
  input  logic             PSEL,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic [WIDTH-1:0] ioIn,
  output logic [WIDTH-1:0] ioOut,
  output logic [WIDTH-1:0] ioOe,
  output logic             irq
);

  apb_state_e state, state_next;
  logic       access;
  logic       wr_en;
  logic [2:0] ofs;
  logic       addr_err;
  logic [31:0] rdata_mux;

  logic [WIDTH-1:0] moder;
  logic [WIDTH-1:0] odr;
  logic [WIDTH-1:0] idr;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] rise_raw;
  logic [WIDTH-1:0] fall_raw;
  logic [WIDTH-1:0] bsrr_set;
  logic [WIDTH-1:0] bsrr_clr;

  // Only PADDR[4:2] and the low PWDATA bits carry meaning
  logic unused_apb;
  assign unused_apb = ^{PADDR[31:5], PADDR[1:0], PWDATA};

  // --------------------------------------------------------------------------
  // Input synchroniser and edge strobes
  // --------------------------------------------------------------------------
  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (PCLK),
    .rst      (PRESET),
    .pin_in   (ioIn),
    .out_mode (moder),
    .sync     (sync),
    .rise_raw (rise_raw),
    .fall_raw (fall_raw)
  );

  assign idr = (moder & odr) | (~moder & sync);

  // --------------------------------------------------------------------------
  // APB handshake
  // --------------------------------------------------------------------------
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (PSEL && PENABLE && !PREADY) begin
          state_next = ACK;
          access     = 1'b1;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // PREADY decodes the state register directly, so reset drops it at once
  assign PREADY = (state == ACK);
  assign ofs    = PADDR[4:2];
  assign wr_en  = access && PWRITE && !addr_err;

  assign bsrr_set = PWDATA[WIDTH-1:0];
  assign bsrr_clr = PWDATA[BSRR_CLR_SHIFT +: WIDTH];

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] isr;
  logic [WIDTH-1:0] isr_set;
  logic [WIDTH-1:0] isr_clr;
  logic             irq_q;
`endif

  // --------------------------------------------------------------------------
  // Read mux / address decode
  // --------------------------------------------------------------------------
  always_comb begin
    rdata_mux = '0;
    addr_err  = 1'b0;
    case (ofs)
      MODER_OFS:   rdata_mux = 32'(moder);
      IDR_OFS:     rdata_mux = 32'(idr);
      ODR_OFS:     rdata_mux = 32'(odr);
      BSRR_OFS:    rdata_mux = '0;
`ifdef GPIO_IRQ_EN
      RISE_EN_OFS: rdata_mux = 32'(rise_en);
      FALL_EN_OFS: rdata_mux = 32'(fall_en);
      ISR_OFS:     rdata_mux = 32'(isr);
`endif
      default:     addr_err  = 1'b1;
    endcase
  end

  // Response registers: loaded on the edge entering ACK, zero otherwise
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else begin
      PRDATA  <= (access && !PWRITE && !addr_err) ? rdata_mux : '0;
      PSLVERR <= access && addr_err;
    end
  end

  // --------------------------------------------------------------------------
  // MODER / ODR
  // --------------------------------------------------------------------------
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      moder <= '0;
      odr   <= '0;
    end else if (wr_en) begin
      case (ofs)
        MODER_OFS: moder <= PWDATA[WIDTH-1:0];
        ODR_OFS:   odr   <= PWDATA[WIDTH-1:0];
        // clear first, then set, so set wins on a shared bit
        BSRR_OFS:  odr   <= (odr & ~bsrr_clr) | bsrr_set;
        default:   ;
      endcase
    end
  end

  assign ioOut = odr;
  assign ioOe  = moder;

  // --------------------------------------------------------------------------
  // Interrupt logic
  // --------------------------------------------------------------------------
`ifdef GPIO_IRQ_EN
  assign isr_set = (rise_raw & rise_en) | (fall_raw & fall_en);
  assign isr_clr = (wr_en && (ofs == ISR_OFS)) ? PWDATA[WIDTH-1:0] : '0;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rise_en <= '0;
      fall_en <= '0;
      isr     <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_en && (ofs == RISE_EN_OFS)) rise_en <= PWDATA[WIDTH-1:0];
      if (wr_en && (ofs == FALL_EN_OFS)) fall_en <= PWDATA[WIDTH-1:0];
      // hardware set applied after W1C, so a coincident edge is kept
      isr   <= (isr & ~isr_clr) | isr_set;
      irq_q <= |isr;
    end
  end

  assign irq = irq_q;
`else
  logic unused_edges;
  assign unused_edges = ^{rise_raw, fall_raw};
  assign irq          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_gpio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_apb_gpio
// Purpose  : Self-checking bench for apb_gpio (WIDTH=8, SYNC_STAGES=2).
//            Table of APB transfers with expected responses queued on SETUP
//            and compared at PREADY, plus hand-written interrupt and
//            reset-during-transfer sequences. Honours GPIO_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_gpio;

  localparam int W    = 8;
  localparam int SYNC = 2;
`ifdef GPIO_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   paddr = '0;
  logic [31:0]   pwdata = '0;
  logic          pwrite = 1'b0;
  logic          penable = 1'b0;
  logic          psel = 1'b0;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;
  logic [W-1:0]  io_in = '0;
  logic [W-1:0]  io_out;
  logic [W-1:0]  io_oe;
  logic          irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_gpio #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .PCLK    (clk),
    .PRESET  (rst),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PWRITE  (pwrite),
    .PENABLE (penable),
    .PSEL    (psel),
    .PRDATA  (prdata),
    .PREADY  (pready),
    .PSLVERR (pslverr),
    .ioIn    (io_in),
    .ioOut   (io_out),
    .ioOe    (io_oe),
    .irq     (irq)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [W-1:0] io;
    logic        chk_rd;
    logic [31:0] rd;
    logic        err;
    logic [W-1:0] out;
    logic [W-1:0] oe;
  } vec_t;

  typedef struct {
    logic        chk_rd;
    logic [31:0] rd;
    logic        err;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [W-1:0] io, input logic chk_rd, input logic [31:0] rd,
                     input logic err, input logic [W-1:0] out, input logic [W-1:0] oe);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.io = io; v.chk_rd = chk_rd;
    v.rd = rd; v.err = err; v.out = out; v.oe = oe;
    vecs.push_back(v);
  endtask

  // One APB transfer; returns the pin state seen during the ACK cycle
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err,
                     input string name, output logic [W-1:0] a_out,
                     output logic [W-1:0] a_oe, output logic a_irq);
    sb_t e;
    int  n;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    e.chk_rd = chk_rd; e.rd = exp_rd; e.err = exp_err;
    sb.push_back(e);
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    @(negedge clk);
    while (!pready && n < 4) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_pready_cycle"}, n, 1);
    e = sb.pop_front();
    if (pready) begin
      chk({name, "_pslverr"}, {31'd0, pslverr}, {31'd0, e.err});
      if (e.chk_rd) chk({name, "_prdata"}, prdata, e.rd);
    end else begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=pready_low required=pready_high", name);
    end
    a_out = io_out; a_oe = io_oe; a_irq = irq;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk({name, "_prdata_idle"}, prdata, 32'd0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic [W-1:0] o, e;
    logic i;
    apb(1'b0, addr, 32'd0, 1'b1, exp, 1'b0, name, o, e, i);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input string name,
                    output logic a_irq);
    logic [W-1:0] o, e;
    apb(1'b1, addr, data, 1'b0, 32'd0, 1'b0, name, o, e, a_irq);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a_out, a_oe;
    logic         a_irq;

    // ---------------- vector table ----------------
    add(0, 32'h00, 32'h0,         8'h00, 1, 32'h0,  1'b0,    8'h00, 8'h00);
    add(0, 32'h04, 32'h0,         8'h00, 1, 32'h0,  1'b0,    8'h00, 8'h00);
    add(0, 32'h08, 32'h0,         8'h00, 1, 32'h0,  1'b0,    8'h00, 8'h00);
    add(0, 32'h0C, 32'h0,         8'h00, 1, 32'h0,  1'b0,    8'h00, 8'h00);
    add(0, 32'h10, 32'h0,         8'h00, 1, 32'h0,  !IRQ_ON, 8'h00, 8'h00);
    add(0, 32'h14, 32'h0,         8'h00, 1, 32'h0,  !IRQ_ON, 8'h00, 8'h00);
    add(0, 32'h18, 32'h0,         8'h00, 1, 32'h0,  !IRQ_ON, 8'h00, 8'h00);
    add(1, 32'h00, 32'hF0,        8'h00, 0, 32'h0,  1'b0,    8'h00, 8'hF0);
    add(1, 32'h08, 32'hA5,        8'h3C, 0, 32'h0,  1'b0,    8'hA5, 8'hF0);
    add(0, 32'h04, 32'h0,         8'h3C, 1, 32'hAC, 1'b0,    8'hA5, 8'hF0);
    add(0, 32'h00, 32'h0,         8'h3C, 1, 32'hF0, 1'b0,    8'hA5, 8'hF0);
    add(0, 32'h08, 32'h0,         8'h3C, 1, 32'hA5, 1'b0,    8'hA5, 8'hF0);
    add(1, 32'h08, 32'h0F,        8'h3C, 0, 32'h0,  1'b0,    8'h0F, 8'hF0);
    add(1, 32'h0C, 32'h00F1_0081, 8'h3C, 0, 32'h0,  1'b0,    8'h8F, 8'hF0);
    add(0, 32'h0C, 32'h0,         8'h3C, 1, 32'h0,  1'b0,    8'h8F, 8'hF0);
    add(0, 32'h08, 32'h0,         8'h3C, 1, 32'h8F, 1'b0,    8'h8F, 8'hF0);
    add(1, 32'h1C, 32'hFF,        8'h3C, 0, 32'h0,  1'b1,    8'h8F, 8'hF0);
    add(0, 32'h1C, 32'h0,         8'h3C, 1, 32'h0,  1'b1,    8'h8F, 8'hF0);
    add(0, 32'h08, 32'h0,         8'h3C, 1, 32'h8F, 1'b0,    8'h8F, 8'hF0);
    add(1, 32'h00, 32'hFFFF_FF00, 8'h3C, 0, 32'h0,  1'b0,    8'h8F, 8'h00);
    add(0, 32'h00, 32'h0,         8'h3C, 1, 32'h0,  1'b0,    8'h8F, 8'h00);
    add(0, 32'h04, 32'h0,         8'h3C, 1, 32'h3C, 1'b0,    8'h8F, 8'h00);
    add(1, 32'h10, 32'h0,         8'h3C, 0, 32'h0,  !IRQ_ON, 8'h8F, 8'h00);

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pready",  {31'd0, pready},  32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("rst_prdata",  prdata,           32'd0);
    chk("rst_irq",     {31'd0, irq},     32'd0);
    chk("rst_ioout",   32'(io_out),      32'd0);
    chk("rst_iooe",    32'(io_oe),       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[k]) begin
      io_in = vecs[k].io;
      apb(vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].chk_rd, vecs[k].rd,
          vecs[k].err, $sformatf("vec%0d", k), a_out, a_oe, a_irq);
      chk($sformatf("vec%0d_ioout", k), 32'(a_out), 32'(vecs[k].out));
      chk($sformatf("vec%0d_iooe", k),  32'(a_oe),  32'(vecs[k].oe));
    end

`ifdef GPIO_IRQ_EN
    // ---------------- edge interrupts ----------------
    io_in = 8'h02;
    repeat (6) @(posedge clk); #1;
    wr(32'h10, 32'h01, "rise_en", a_irq);
    wr(32'h14, 32'h02, "fall_en", a_irq);
    rd(32'h18, 32'h00, "isr_idle");
    @(posedge clk); #1;
    io_in = 8'h03;
    repeat (SYNC + 1) @(posedge clk);
    @(negedge clk);
    chk("isr_rise_latency", 32'(dut.isr), 32'h01);
    chk("irq_before_lag",   {31'd0, irq}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("irq_after_lag",    {31'd0, irq}, 32'd1);
    #1;
    rd(32'h18, 32'h01, "isr_rise");
    io_in = 8'h01;
    repeat (6) @(posedge clk); #1;
    rd(32'h18, 32'h03, "isr_fall");
    wr(32'h18, 32'h01, "w1c_bit0", a_irq);
    rd(32'h18, 32'h02, "isr_after_w1c0");
    wr(32'h18, 32'h02, "w1c_bit1", a_irq);
    chk("irq_in_ack_of_clear", {31'd0, a_irq}, 32'd1);
    chk("irq_cycle_after_clear", {31'd0, irq}, 32'd0);
    rd(32'h18, 32'h00, "isr_cleared");

    // rising edge on pin 0 lands on the W1C commit edge
    io_in = 8'h00;
    repeat (6) @(posedge clk);
    #1;
    rd(32'h18, 32'h00, "isr_pre_collide");
    @(posedge clk); #1;
    io_in = 8'h01;
    repeat (SYNC - 2) @(posedge clk);
    wr(32'h18, 32'h01, "w1c_collide", a_irq);
    rd(32'h18, 32'h01, "isr_collide_kept");
    chk("irq_collide", {31'd0, irq}, 32'd1);
`else
    // edges present on the pins, but no interrupt logic exists
    io_in = 8'h00;
    repeat (6) @(posedge clk);
    io_in = 8'hFF;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("irq_tied_low", {31'd0, irq}, 32'd0);
    #1;
    rd(32'h04, 32'hFF, "idr_all_high");
`endif

    // ---------------- reset before the write commits ----------------
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hFF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstA_pready", {31'd0, pready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rstA_pready_held", {31'd0, pready}, 32'd0);
    chk("rstA_ioout",       32'(io_out),     32'd0);
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    rd(32'h08, 32'h00, "rstA_odr");

    // ---------------- reset during ACK: PREADY drops at once ----------------
    wr(32'h08, 32'h55, "pre_rstB", a_irq);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hFF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstB_pready_ack", {31'd0, pready}, 32'd1);
    chk("rstB_ioout_ack",  32'(io_out),     32'hFF);
    rst = 1'b1;
    #1;
    chk("rstB_pready_async", {31'd0, pready}, 32'd0);
    chk("rstB_ioout_async",  32'(io_out),     32'd0);
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    rd(32'h08, 32'h00, "rstB_odr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
